// File: rtl/score_pkg.sv
// Shared types and helpers for the score bank: power-up codes, BCD digit type,
// and a single-digit BCD add with carry.
package score_pkg;

  localparam logic [1:0] PU_NONE   = 2'd0;
  localparam logic [1:0] PU_DOUBLE = 2'd1;
  localparam logic [1:0] PU_BONUS  = 2'd2;
  localparam logic [1:0] PU_FREEZE = 2'd3;

  typedef logic [3:0] bcd_t;

  // Returns {carry, digit}. A binary sum above 9 is pushed past 15 by adding 6,
  // which leaves the decimal carry in bit 4 and the corrected digit below it.
  function automatic logic [4:0] bcd_add(input bcd_t a, input bcd_t b, input logic cin);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    bcd_add = (s > 5'd9) ? s + 5'd6 : s;
  endfunction

endpackage

// File: rtl/hit_debounce.sv
// Per-player 2-flop synchroniser and level debounce filter. rise is a
// combinational strobe, high in the cycle before filt steps from 0 to 1.
module hit_debounce #(
  parameter int DEBOUNCE = 16
) (
  input  logic clock,
  input  logic resetn,
  input  logic hit_raw,
  output logic filt,
  output logic rise
);
  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic [1:0]    sync_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          s;

  assign s = sync_q[1];

  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (s == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
      filt_d = s;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], hit_raw};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt = filt_q;
  assign rise = filt_d & ~filt_q;

endmodule

// File: rtl/score_bank.sv
// Multi-player debounced BCD scoring with saturation and leader tracking.
// Leader comparator only exists when SCORE_BANK_LEADER_EN is defined.
module score_bank
  import score_pkg::*;
#(
  parameter  int NUM_PLAYERS = 2,
  parameter  int DIGITS      = 4,
  parameter  int DEBOUNCE    = 16,
  parameter  int BONUS       = 5,
  localparam int LW          = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                            clock,
  input  logic                            resetn,
  input  logic                            clear,
  input  logic                            run,
  input  logic [NUM_PLAYERS-1:0]          hit_raw,
  input  logic [2*NUM_PLAYERS-1:0]        powerup,
  output logic [4*DIGITS*NUM_PLAYERS-1:0] score_bcd,
  output logic [NUM_PLAYERS-1:0]          hit_pulse,
  output logic [NUM_PLAYERS-1:0]          saturated,
  output logic [LW-1:0]                   leader,
  output logic                            leader_valid
);
  logic [NUM_PLAYERS-1:0][DIGITS-1:0][3:0] scores;
  logic [NUM_PLAYERS-1:0]                  filt, rise;

  assign score_bcd = scores;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_pl
    logic [DIGITS-1:0][3:0] score_q, score_d, sum;
    logic                   sat_q, sat_d, pulse_q, acc;
    bcd_t                   inc;
    logic                   cy;
    logic [4:0]             t;

    hit_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
      .clock  (clock),
      .resetn (resetn),
      .hit_raw(hit_raw[p]),
      .filt   (filt[p]),
      .rise   (rise[p])
    );

    assign acc = rise[p] & ~filt[p] & run & ~clear;

    always_comb begin
      case (powerup[2*p +: 2])
        PU_NONE:   inc = 4'd1;
        PU_DOUBLE: inc = 4'd2;
        PU_BONUS:  inc = 4'(BONUS);
        default:   inc = 4'd0;
      endcase
      cy  = 1'b0;
      t   = '0;
      sum = '0;
      for (int d = 0; d < DIGITS; d++) begin
        t      = bcd_add(score_q[d], (d == 0) ? inc : 4'd0, cy);
        sum[d] = t[3:0];
        cy     = t[4];
      end
      score_d = score_q;
      sat_d   = sat_q;
      if (acc) begin
        score_d = cy ? {DIGITS{4'h9}} : sum;
        sat_d   = sat_q | cy;
      end
      if (clear) begin
        score_d = '0;
        sat_d   = 1'b0;
      end
    end

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        score_q <= '0;
        sat_q   <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        score_q <= score_d;
        sat_q   <= sat_d;
        pulse_q <= acc;
      end
    end

    assign scores[p]    = score_q;
    assign saturated[p] = sat_q;
    assign hit_pulse[p] = pulse_q;
  end

`ifdef SCORE_BANK_LEADER_EN
  logic [LW-1:0]          lead_q, lead_d;
  logic                   lv_q, lv_d;
  logic [4*DIGITS-1:0]    best;

  // BCD ordering matches numeric ordering, so a plain unsigned compare works.
  always_comb begin
    lead_d = '0;
    lv_d   = 1'b0;
    best   = scores[0];
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (scores[p] != '0) lv_d = 1'b1;
      if (scores[p] > best) begin
        best   = scores[p];
        lead_d = LW'(p);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      lead_q <= '0;
      lv_q   <= 1'b0;
    end else begin
      lead_q <= lead_d;
      lv_q   <= lv_d;
    end
  end

  assign leader       = lead_q;
  assign leader_valid = lv_q;
`else
  assign leader       = '0;
  assign leader_valid = 1'b0;
`endif

endmodule

// File: tb/tb_score_bank.sv
// Randomised bench for score_bank against a decimal-integer scoring model.
module tb_score_bank;
  localparam int NP   = 3;
  localparam int DG   = 2;
  localparam int DB   = 4;
  localparam int BN   = 5;
  localparam int LW   = 2;
  localparam int MAXS = (10 ** DG) - 1;

  logic               clock = 1'b0;
  logic               resetn, clear, run;
  logic [NP-1:0]      hit_raw;
  logic [2*NP-1:0]    powerup;
  logic [4*DG*NP-1:0] score_bcd;
  logic [NP-1:0]      hit_pulse, saturated;
  logic [LW-1:0]      leader;
  logic               leader_valid;

  always #5 clock = ~clock;

  score_bank #(.NUM_PLAYERS(NP), .DIGITS(DG), .DEBOUNCE(DB), .BONUS(BN)) dut (
    .clock(clock), .resetn(resetn), .clear(clear), .run(run),
    .hit_raw(hit_raw), .powerup(powerup), .score_bcd(score_bcd),
    .hit_pulse(hit_pulse), .saturated(saturated),
    .leader(leader), .leader_valid(leader_valid)
  );

  // Model: scores as plain integers; a level is accepted after it has
  // disagreed with the filtered level for DB consecutive synchronised cycles.
  int sc[NP];
  bit sat[NP], filt[NP], pls[NP], r1[NP], r2[NP];
  int mism[NP];
  int ldr;
  bit lv;
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] to_bcd(input int v);
    logic [63:0] r;
    r = '0;
    for (int d = 0; d < DG; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic model_reset;
    for (int p = 0; p < NP; p++) begin
      sc[p] = 0; sat[p] = 0; filt[p] = 0; pls[p] = 0;
      r1[p] = 0; r2[p] = 0; mism[p] = 0;
    end
    ldr = 0; lv = 0;
  endtask

  task automatic model_edge;
    int best, inc;
    bit s;
    best = sc[0]; ldr = 0; lv = 0;
    for (int p = 0; p < NP; p++) begin
      if (sc[p] != 0) lv = 1;
      if (sc[p] > best) begin best = sc[p]; ldr = p; end
    end
`ifndef SCORE_BANK_LEADER_EN
    ldr = 0; lv = 0;
`endif
    for (int p = 0; p < NP; p++) begin
      pls[p] = 0;
      s = r2[p]; r2[p] = r1[p]; r1[p] = hit_raw[p];
      if (s == filt[p]) mism[p] = 0;
      else begin
        mism[p]++;
        if (mism[p] == DB) begin
          filt[p] = s; mism[p] = 0;
          if (s && run && !clear) begin
            pls[p] = 1;
            case (powerup[2*p +: 2])
              2'd0: inc = 1;
              2'd1: inc = 2;
              2'd2: inc = BN;
              default: inc = 0;
            endcase
            if (sc[p] + inc > MAXS) begin sc[p] = MAXS; sat[p] = 1; end
            else sc[p] = sc[p] + inc;
          end
        end
      end
    end
    if (clear) for (int p = 0; p < NP; p++) begin sc[p] = 0; sat[p] = 0; end
  endtask

  task automatic check_all(input string ph);
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("%s score%0d", ph, p), 64'(score_bcd[4*DG*p +: 4*DG]), to_bcd(sc[p]));
      chk($sformatf("%s pulse%0d", ph, p), 64'(hit_pulse[p]), 64'(pls[p]));
      chk($sformatf("%s sat%0d", ph, p), 64'(saturated[p]), 64'(sat[p]));
    end
    chk({ph, " leader"}, 64'(leader), 64'(ldr));
    chk({ph, " leader_valid"}, 64'(leader_valid), 64'(lv));
  endtask

  task automatic step(input string ph);
    @(posedge clock);
    model_edge();
    #1;
    check_all(ph);
  endtask

  task automatic hit(input int p, input logic [1:0] pu, input string ph);
    powerup[2*p +: 2] = pu;
    hit_raw[p] = 1'b1;
    repeat (DB + 4) step(ph);
    hit_raw[p] = 1'b0;
    repeat (DB + 4) step(ph);
  endtask

  task automatic do_reset;
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; clear = 1'b0; run = 1'b1; hit_raw = '0; powerup = '0;
    model_reset();
    #2;
    check_all("reset");
    resetn = 1'b1;

    step("idle");
    hit(0, 2'd0, "first_hit");

    hit_raw[1] = 1'b1;
    repeat (3) step("glitch");
    hit_raw[1] = 1'b0;
    repeat (8) step("glitch");
    hit(1, 2'd1, "double");

    clear = 1'b1; step("clr");
    clear = 1'b0;
    powerup = '0;
    hit_raw[1:0] = 2'b11;
    repeat (DB + 4) step("tie");
    hit_raw[1:0] = 2'b00;
    repeat (DB + 4) step("tie");

    repeat (19) hit(2, 2'd2, "bonus");
    repeat (3) hit(2, 2'd0, "to98");
    hit(2, 2'd2, "saturate");
    hit(2, 2'd1, "post_sat");

    powerup[1:0] = 2'd0;
    hit_raw[0] = 1'b1;
    repeat (DB + 1) step("pre_clr_hit");
    clear = 1'b1;
    step("clr_hit");
    chk("clr_hit no pulse", 64'(hit_pulse[0]), 64'd0);
    clear = 1'b0;
    repeat (10) step("held_beam");
    hit_raw[0] = 1'b0;
    repeat (DB + 4) step("held_beam");

    run = 1'b0;
    hit_raw[0] = 1'b1;
    repeat (DB + 4) step("run_off");
    run = 1'b1;
    repeat (4) step("run_back");
    hit_raw[0] = 1'b0;
    repeat (DB + 4) step("run_back");

    for (int i = 0; i < 1500; i++) begin
      for (int p = 0; p < NP; p++)
        if ($urandom_range(0, 6) == 0) hit_raw[p] = ~hit_raw[p];
      powerup = 6'($urandom);
      run     = ($urandom_range(0, 15) != 0);
      clear   = ($urandom_range(0, 99) == 0);
      if (i == 700) do_reset();
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/score_bank.md
# score_bank

Parametrised multi-player scoring engine for the game datapath: it debounces each player's raw IR hit bit, applies that player's power-up rule, and accumulates a saturating BCD score per player. It also reports the current leader. It sits between the IR receiver inputs and the VGA controller's score-digit and leaderboard inputs, replacing separate per-player score calculators and binary-to-digit converters. Scores are produced directly in BCD, so no division logic is needed downstream.

## Interface
Parameters:
- NUM_PLAYERS, 2, number of independent player channels (1..8)
- DIGITS, 4, BCD digits per score (1..8)
- DEBOUNCE, 16, consecutive synchronised cycles a new hit level must persist before acceptance (≥1)
- BONUS, 5, increment applied for power-up code 2 (1..9)

Ports:
- clock  in  1  system clock; all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear of all scores and saturation flags
- run  in  1  scoring enable (game active, not times_up)
- hit_raw  in  NUM_PLAYERS  raw, unsynchronised IR hit bit per player
- powerup  in  2*NUM_PLAYERS  power-up code per player, player p at [2p+1:2p]
- score_bcd  out  4*DIGITS*NUM_PLAYERS  BCD score; player p at [4*DIGITS*(p+1)-1 : 4*DIGITS*p], digit 0 is the ones digit
- hit_pulse  out  NUM_PLAYERS  one-cycle pulse for each accepted hit
- saturated  out  NUM_PLAYERS  score has clamped at all nines
- leader  out  LW  index of the highest-scoring player, where LW = max(1, $clog2(NUM_PLAYERS))
- leader_valid  out  1  at least one score is nonzero

## Operation
- Per player: 2-flop synchroniser producing s; debounce filter holds filt and cnt.
  - s == filt: cnt <= 0.
  - s != filt and cnt == DEBOUNCE-1: filt <= s, cnt <= 0.
  - Otherwise cnt <= cnt+1.
- A hit is accepted on the edge where filt goes 0→1 while run=1 and clear=0.
- On acceptance, the increment is chosen from the powerup code sampled at that edge:
  - 0: +1
  - 1: +2
  - 2: +BONUS
  - 3: +0 (frozen; hit_pulse still fires)
- BCD add: the increment (0..9) is added to digit 0 with a decimal carry rippling through all DIGITS digits, combinationally within one cycle.
- Saturation: if a carry would leave the top digit, the score becomes all 9s and saturated=1. Further hits pulse but do not change the score.
- run=0: the filters keep tracking and filt edges are discarded. No pulse occurs, and edges are not queued for later.
- clear=1: all scores go to 0 and saturated to 0. It overrides a same-cycle acceptance, which is dropped and produces no pulse. Filter state is untouched, so a beam held through clear does not re-fire.
- Leader: registered comparison of all scores as unsigned values. Ties go to the lowest index. leader_valid=0 when all scores are 0 (leader then reads 0).
- Players are fully independent. Simultaneous hits on different players all apply in the same cycle.

## Timing
- Reset values: score_bcd=0, hit_pulse=0, saturated=0, leader=0, leader_valid=0. Synchroniser, filt, and cnt are all 0.
- If hit_raw is first sampled high at edge k and held, hit_pulse and score_bcd update at edge k+DEBOUNCE+1. hit_pulse is high for exactly one cycle.
- If hit_raw falls before DEBOUNCE consecutive mismatching cycles, cnt restarts and no hit occurs.
- A re-hit requires filt to return to 0 (DEBOUNCE low cycles), then DEBOUNCE high cycles.
- leader and leader_valid lag score_bcd by one edge.
- Reset asserted mid-debounce or mid-game: all state returns to reset values immediately (asynchronous).

## Configuration
- SCORE_BANK_LEADER_EN defined: the leader comparator and registers are compiled in, as described above.
- SCORE_BANK_LEADER_EN undefined: no comparator logic is built; leader is tied to 0 and leader_valid to 0.

## Structure
- Shared package score_pkg holds:
  - power-up code constants (PU_NONE=0, PU_DOUBLE=1, PU_BONUS=2, PU_FREEZE=3)
  - the 4-bit BCD digit type
  - a BCD single-digit add-with-carry function
- Sub-module hit_debounce contains the synchroniser plus filter and outputs filt and a rise strobe. It is instantiated NUM_PLAYERS times via generate.
- Score accumulation, saturation, and the leader comparator stay in score_bank.

## Test plan
- Reset, DEBOUNCE=4, run=1, powerup=0: hold hit_raw[0] high from edge 10 → hit_pulse[0] at edge 15 only; score player 0 = 0001; leader=0, leader_valid=1 at edge 16.
- 3-cycle glitch on hit_raw[1] with DEBOUNCE=4 → no pulse, score unchanged; then a hit with powerup=1 → player 1 score 0002, leader=1.
- DIGITS=2, preload via hits to 98, hit with powerup=2 (BONUS=5) → score 99, saturated=1. Next hit → pulse, score stays 99.
- Simultaneous accepted hits on players 0 and 1 with equal resulting scores → both update in the same cycle; leader=0 (tie to lowest index).
- Hit acceptance coincident with clear=1 → no pulse, all scores 0. Holding the beam afterwards does not re-fire. run=0 during a hit → filter tracks, no pulse, no score change.
- Build without SCORE_BANK_LEADER_EN → leader=0 and leader_valid=0 throughout scoring.
